// File: rtl/ex_mem_flag_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_flag_stage
//
// EX->MEM pipeline boundary of the 16-bit core.
//  * Registers the EX instruction (opcode, ALU result, destination, write
//    enable) into the MEM stage with one cycle of latency.
//  * Owns the architectural Z/V/N flag register. V is derived from the raw
//    operands because the ALU's ADD/SUB results are saturated and cannot
//    reveal overflow themselves.
//  * Evaluates the 3-bit branch condition for the branch currently in ID.
//  * Tracks a sticky halted state once HLT reaches MEM.
//
// Optional feature (compile-time macro FLAG_BYPASS_EN):
//  defined   : branches see the flags being produced by the EX instruction
//              in the same cycle; flag_hazard is tied low.
//  undefined : branches see only the registered flags; flag_hazard tells the
//              control unit to hold the branch in ID for a cycle.
//
// Ports
//  clk, rst_n                  clock (rising edge), async active-low reset
//  stall, flush                pipeline control (flush has priority)
//  ex_valid/opcode/a/b/alu_res/rd/wr_en   EX-stage instruction
//  br_valid, br_ccc            branch in ID and its condition code
//  mem_valid/opcode/result/rd/wr_en       MEM-stage registers
//  flag_z, flag_v, flag_n      architectural flags
//  br_taken                    branch condition satisfied
//  flag_hazard                 ID branch must stall (no-bypass build only)
//  halted                      sticky halt indication
// ---------------------------------------------------------------------------
module ex_mem_flag_stage #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_wr_en,
  input  logic              br_valid,
  input  logic [2:0]        br_ccc,
  output logic              mem_valid,
  output logic [OPC_W-1:0]  mem_opcode,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_wr_en,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              br_taken,
  output logic              flag_hazard,
  output logic              halted
);

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_SLL = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_SRA = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_ROR = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  typedef enum logic [2:0] {
    CC_NE   = 3'b000,
    CC_EQ   = 3'b001,
    CC_GT   = 3'b010,
    CC_LT   = 3'b011,
    CC_GTE  = 3'b100,
    CC_LTE  = 3'b101,
    CC_OVFL = 3'b110,
    CC_UNC  = 3'b111
  } ccc_e;

  logic              mem_valid_q, mem_wr_en_q;
  logic [OPC_W-1:0]  mem_opcode_q;
  logic [DATA_W-1:0] mem_result_q;
  logic [REG_W-1:0]  mem_rd_q;
  logic              flag_z_q, flag_v_q, flag_n_q;
  logic              flag_z_d, flag_v_d, flag_n_d;
  logic              halted_q;

  logic              acc;
  logic              writes_zvn, writes_z;
  logic [DATA_W:0]   sum_x, diff_x;
  logic              v_add, v_sub;
  logic              eff_z, eff_v, eff_n;
  logic              cond;

  // Instruction is accepted into MEM on this edge.
  assign acc = ex_valid & ~flush & ~stall & ~halted_q;

  // Overflow: the sign-extended (DATA_W+1)-bit result is not representable
  // in DATA_W bits exactly when its top two bits differ.
  always_comb begin
    sum_x  = {ex_a[DATA_W-1], ex_a} + {ex_b[DATA_W-1], ex_b};
    diff_x = {ex_a[DATA_W-1], ex_a} - {ex_b[DATA_W-1], ex_b};
    v_add  = (sum_x  != {sum_x[DATA_W-1],  sum_x[DATA_W-1:0]});
    v_sub  = (diff_x != {diff_x[DATA_W-1], diff_x[DATA_W-1:0]});
  end

  // Next-flag values. The defaults hold the register, so with acc=0 these
  // equal the registered flags.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    writes_zvn = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
    writes_z   = writes_zvn || (ex_opcode == OP_XOR) || (ex_opcode == OP_SLL) ||
                 (ex_opcode == OP_SRA) || (ex_opcode == OP_ROR);
    flag_z_d   = flag_z_q;
    flag_v_d   = flag_v_q;
    flag_n_d   = flag_n_q;
    if (acc && writes_z) begin
      flag_z_d = (ex_alu_res == '0);
    end
    if (acc && writes_zvn) begin
      flag_n_d = ex_alu_res[DATA_W-1];
      flag_v_d = (ex_opcode == OP_SUB) ? v_sub : v_add;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. All registers,
  // datapath included, are reset so the MEM outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_opcode_q <= '0;
      mem_result_q <= '0;
      mem_rd_q     <= '0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      // acc already excludes flush and stall, so flags move only on acc edges.
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
      flag_n_q <= flag_n_d;
      if (acc && (ex_opcode == OP_HLT)) begin
        halted_q <= 1'b1;
      end
      if (flush || (!stall && !acc)) begin
        // Bubble; payload fields keep stale contents.
        mem_valid_q <= 1'b0;
        mem_wr_en_q <= 1'b0;
      end else if (acc) begin
        mem_valid_q  <= 1'b1;
        mem_wr_en_q  <= ex_wr_en;
        mem_opcode_q <= ex_opcode;
        mem_result_q <= ex_alu_res;
        mem_rd_q     <= ex_rd;
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  assign eff_z       = flag_z_d;
  assign eff_v       = flag_v_d;
  assign eff_n       = flag_n_d;
  assign flag_hazard = 1'b0;
`else
  assign eff_z       = flag_z_q;
  assign eff_v       = flag_v_q;
  assign eff_n       = flag_n_q;
  // Raised regardless of stall/flush: the control unit decides what to hold.
  assign flag_hazard = br_valid & ex_valid & ~halted_q & writes_z;
`endif

  always_comb begin
    cond = 1'b0;
    case (ccc_e'(br_ccc))
      CC_NE:   cond = ~eff_z;
      CC_EQ:   cond = eff_z;
      CC_GT:   cond = ~eff_z & ~eff_n;
      CC_LT:   cond = eff_n;
      CC_GTE:  cond = eff_z | ~eff_n;
      CC_LTE:  cond = eff_z | eff_n;
      CC_OVFL: cond = eff_v;
      CC_UNC:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign br_taken   = br_valid & cond;
  assign mem_valid  = mem_valid_q;
  assign mem_wr_en  = mem_wr_en_q & mem_valid_q;
  assign mem_opcode = mem_opcode_q;
  assign mem_result = mem_result_q;
  assign mem_rd     = mem_rd_q;
  assign flag_z     = flag_z_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;
  assign halted     = halted_q;

endmodule
